// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: control-word types shared by decode, ctrl_pipe and the E/M/W datapath.
// Each stage struct nests the struct of the following stage, so a stage register
// carries its own controls plus everything still needed downstream.
package ctrl_pipe_pkg;

  localparam int unsigned ALU_CTRL_WIDTH = 3;

  // Writeback-stage controls
  typedef struct packed {
    logic resultSelector;
    logic writeEnableScalar;
    logic writeEnableVector;
  } ctrl_w_t;

  // Memory-stage controls plus the writeback controls riding along
  typedef struct packed {
    logic    writeToMemoryEnable;
    logic    outFlag;
    ctrl_w_t w;
  } ctrl_m_t;

  // Execute-stage controls plus everything for M and W
  typedef struct packed {
    logic                      isScalarInstruction;
    logic                      isVectorScalarOperation;
    logic                      useInmediate;
    logic [ALU_CTRL_WIDTH-1:0] aluControl;
    ctrl_m_t                   m;
  } ctrl_e_t;

  // NOP words: identical to the decode of opcode 4'b0000 (all fields zero)
  localparam ctrl_w_t CTRL_W_NOP = '0;
  localparam ctrl_m_t CTRL_M_NOP = '0;
  localparam ctrl_e_t CTRL_E_NOP = '0;

endpackage

// File: rtl/ctrl_stage_reg.sv
// ctrl_stage_reg: one pipeline stage register (valid, destReg, control struct).
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   hold              keep current contents (wins over clear)
//   clear             load the NOP word instead of the incoming values
//   loadValid/loadDest/loadCtrl  values captured on a normal advance
//   valid/dest/ctrl   registered stage contents
// Priority per edge: reset > hold > clear > load.
module ctrl_stage_reg #(
  parameter type         T              = logic,
  parameter T            NOP            = '0,
  parameter int unsigned REG_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hold,
  input  logic                      clear,
  input  logic                      loadValid,
  input  logic [REG_ADDR_WIDTH-1:0] loadDest,
  input  T                          loadCtrl,
  output logic                      valid,
  output logic [REG_ADDR_WIDTH-1:0] dest,
  output T                          ctrl
);

  // Stage register with hold and clear-to-NOP
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      dest  <= '0;
      ctrl  <= NOP;
    end else if (hold) begin
      valid <= valid;
      dest  <= dest;
      ctrl  <= ctrl;
    end else if (clear) begin
      valid <= 1'b0;
      dest  <= '0;
      ctrl  <= NOP;
    end else begin
      valid <= loadValid;
      dest  <= loadDest;
      ctrl  <= loadCtrl;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries decoded control from decode through the E, M and W stage registers.
// Optional feature macro: CTRL_PIPE_PERF_EN adds saturating retiredCount/bubbleCount.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   validD, *ED, *MD, *WBD      decode-stage valid, control fields, destRegD
//   stallAll                    freeze all stage registers
//   bubbleE                     load NOP into Execute while M/W keep draining
//   validE/M/W, destRegE/M/W    stage occupancy and destination index (unqualified)
//   *E, *M, *W controls         per-stage control outputs; side effects gated by valid
//   retiredCount, bubbleCount   performance counters (CTRL_PIPE_PERF_EN only)
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 4
`ifdef CTRL_PIPE_PERF_EN
  , parameter int unsigned CNT_WIDTH = 32
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      validD,
  input  logic                      isScalarInstructionED,
  input  logic                      isVectorScalarOperationED,
  input  logic                      useInmediateED,
  input  logic [ALU_CTRL_WIDTH-1:0] aluControlED,
  input  logic                      writeToMemoryEnableMD,
  input  logic                      outFlagMD,
  input  logic                      resultSelectorWBD,
  input  logic                      writeEnableScalarWBD,
  input  logic                      writeEnableVectorWBD,
  input  logic [REG_ADDR_WIDTH-1:0] destRegD,
  input  logic                      stallAll,
  input  logic                      bubbleE,
  output logic                      validE,
  output logic                      validM,
  output logic                      validW,
  output logic                      isScalarInstructionE,
  output logic                      isVectorScalarOperationE,
  output logic                      useInmediateE,
  output logic [ALU_CTRL_WIDTH-1:0] aluControlE,
  output logic                      writeToMemoryEnableM,
  output logic                      outFlagM,
  output logic                      resultSelectorW,
  output logic                      writeEnableScalarW,
  output logic                      writeEnableVectorW,
  output logic [REG_ADDR_WIDTH-1:0] destRegE,
  output logic [REG_ADDR_WIDTH-1:0] destRegM,
  output logic [REG_ADDR_WIDTH-1:0] destRegW
`ifdef CTRL_PIPE_PERF_EN
  , output logic [CNT_WIDTH-1:0]    retiredCount
  , output logic [CNT_WIDTH-1:0]    bubbleCount
`endif
);

  ctrl_e_t ctrlD;
  ctrl_e_t ctrlE;
  ctrl_m_t ctrlM;
  ctrl_w_t ctrlW;
  logic    clearE;

  // Pack decode inputs into the Execute control word
  always_comb begin
    ctrlD                           = CTRL_E_NOP;
    ctrlD.isScalarInstruction       = isScalarInstructionED;
    ctrlD.isVectorScalarOperation   = isVectorScalarOperationED;
    ctrlD.useInmediate              = useInmediateED;
    ctrlD.aluControl                = aluControlED;
    ctrlD.m.writeToMemoryEnable     = writeToMemoryEnableMD;
    ctrlD.m.outFlag                 = outFlagMD;
    ctrlD.m.w.resultSelector        = resultSelectorWBD;
    ctrlD.m.w.writeEnableScalar     = writeEnableScalarWBD;
    ctrlD.m.w.writeEnableVector     = writeEnableVectorWBD;
  end

  // A bubble or an empty decode slot both put a NOP into Execute
  assign clearE = bubbleE | ~validD;

  ctrl_stage_reg #(
    .T              (ctrl_e_t),
    .NOP            (CTRL_E_NOP),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) stageE (
    .clk       (clk),
    .reset     (reset),
    .hold      (stallAll),
    .clear     (clearE),
    .loadValid (validD),
    .loadDest  (destRegD),
    .loadCtrl  (ctrlD),
    .valid     (validE),
    .dest      (destRegE),
    .ctrl      (ctrlE)
  );

  ctrl_stage_reg #(
    .T              (ctrl_m_t),
    .NOP            (CTRL_M_NOP),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) stageM (
    .clk       (clk),
    .reset     (reset),
    .hold      (stallAll),
    .clear     (1'b0),
    .loadValid (validE),
    .loadDest  (destRegE),
    .loadCtrl  (ctrlE.m),
    .valid     (validM),
    .dest      (destRegM),
    .ctrl      (ctrlM)
  );

  ctrl_stage_reg #(
    .T              (ctrl_w_t),
    .NOP            (CTRL_W_NOP),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) stageW (
    .clk       (clk),
    .reset     (reset),
    .hold      (stallAll),
    .clear     (1'b0),
    .loadValid (validM),
    .loadDest  (destRegM),
    .loadCtrl  (ctrlM.w),
    .valid     (validW),
    .dest      (destRegW),
    .ctrl      (ctrlW)
  );

  // Non-side-effect fields straight from the registers
  assign isScalarInstructionE     = ctrlE.isScalarInstruction;
  assign isVectorScalarOperationE = ctrlE.isVectorScalarOperation;
  assign useInmediateE            = ctrlE.useInmediate;
  assign aluControlE              = ctrlE.aluControl;
  assign resultSelectorW          = ctrlW.resultSelector;

  // Side effects qualified by stage valid so an empty stage never writes
  assign writeToMemoryEnableM = ctrlM.writeToMemoryEnable & validM;
  assign outFlagM             = ctrlM.outFlag & validM;
  assign writeEnableScalarW   = ctrlW.writeEnableScalar & validW;
  assign writeEnableVectorW   = ctrlW.writeEnableVector & validW;

`ifdef CTRL_PIPE_PERF_EN
  // Saturating retire/bubble counters; frozen while the pipe is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      retiredCount <= '0;
      bubbleCount  <= '0;
    end else if (!stallAll) begin
      if (validW && (retiredCount != '1)) begin
        retiredCount <= retiredCount + CNT_WIDTH'(1);
      end
      if (bubbleE && (bubbleCount != '1)) begin
        bubbleCount <= bubbleCount + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed self-checking bench for ctrl_pipe (default and CTRL_PIPE_PERF_EN builds).
module tb_ctrl_pipe;

  localparam int unsigned RW = 4;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          validD;
  logic          isScalarInstructionED, isVectorScalarOperationED, useInmediateED;
  logic [2:0]    aluControlED;
  logic          writeToMemoryEnableMD, outFlagMD;
  logic          resultSelectorWBD, writeEnableScalarWBD, writeEnableVectorWBD;
  logic [RW-1:0] destRegD;
  logic          stallAll, bubbleE;
  logic          validE, validM, validW;
  logic          isScalarInstructionE, isVectorScalarOperationE, useInmediateE;
  logic [2:0]    aluControlE;
  logic          writeToMemoryEnableM, outFlagM;
  logic          resultSelectorW, writeEnableScalarW, writeEnableVectorW;
  logic [RW-1:0] destRegE, destRegM, destRegW;
`ifdef CTRL_PIPE_PERF_EN
  logic [CW-1:0] retiredCount, bubbleCount;
`endif

  int nCmp = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  ctrl_pipe #(
    .REG_ADDR_WIDTH (RW)
`ifdef CTRL_PIPE_PERF_EN
    , .CNT_WIDTH    (CW)
`endif
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .validD                    (validD),
    .isScalarInstructionED     (isScalarInstructionED),
    .isVectorScalarOperationED (isVectorScalarOperationED),
    .useInmediateED            (useInmediateED),
    .aluControlED              (aluControlED),
    .writeToMemoryEnableMD     (writeToMemoryEnableMD),
    .outFlagMD                 (outFlagMD),
    .resultSelectorWBD         (resultSelectorWBD),
    .writeEnableScalarWBD      (writeEnableScalarWBD),
    .writeEnableVectorWBD      (writeEnableVectorWBD),
    .destRegD                  (destRegD),
    .stallAll                  (stallAll),
    .bubbleE                   (bubbleE),
    .validE                    (validE),
    .validM                    (validM),
    .validW                    (validW),
    .isScalarInstructionE      (isScalarInstructionE),
    .isVectorScalarOperationE  (isVectorScalarOperationE),
    .useInmediateE             (useInmediateE),
    .aluControlE               (aluControlE),
    .writeToMemoryEnableM      (writeToMemoryEnableM),
    .outFlagM                  (outFlagM),
    .resultSelectorW           (resultSelectorW),
    .writeEnableScalarW        (writeEnableScalarW),
    .writeEnableVectorW        (writeEnableVectorW),
    .destRegE                  (destRegE),
    .destRegM                  (destRegM),
    .destRegW                  (destRegW)
`ifdef CTRL_PIPE_PERF_EN
    , .retiredCount            (retiredCount)
    , .bubbleCount             (bubbleCount)
`endif
  );

  // Advance one edge; outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an instruction at decode: {isS, isVS, imm}, alu, {wm, of}, {rs, wes, wev}, dest
  task automatic setD(input logic v, input logic [2:0] eBits, input logic [2:0] alu,
                      input logic [1:0] mBits, input logic [2:0] wBits, input logic [RW-1:0] dst);
    validD                    = v;
    isScalarInstructionED     = eBits[2];
    isVectorScalarOperationED = eBits[1];
    useInmediateED            = eBits[0];
    aluControlED              = alu;
    writeToMemoryEnableMD     = mBits[1];
    outFlagMD                 = mBits[0];
    resultSelectorWBD         = wBits[2];
    writeEnableScalarWBD      = wBits[1];
    writeEnableVectorWBD      = wBits[0];
    destRegD                  = dst;
  endtask

  task automatic clrD();
    setD(1'b0, 3'b000, 3'b000, 2'b00, 3'b000, '0);
  endtask

  initial begin
    reset    = 1'b1;
    stallAll = 1'b0;
    bubbleE  = 1'b0;
    clrD();
    #2;

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    chk("rst_validE", 32'(validE), 32'd0);
    chk("rst_validW", 32'(validW), 32'd0);
    chk("rst_aluE", 32'(aluControlE), 32'd0);
    chk("rst_weScalarW", 32'(writeEnableScalarW), 32'd0);
    chk("rst_destW", 32'(destRegW), 32'd0);
`ifdef CTRL_PIPE_PERF_EN
    chk("rst_retired", retiredCount, 32'd0);
    chk("rst_bubbles", bubbleCount, 32'd0);
`endif

    // Single instruction traverses E, M, W with 1/2/3-cycle latency
    setD(1'b1, 3'b010, 3'b001, 2'b01, 3'b110, 4'd5);
    tick();
    clrD();
    chk("one_aluE", 32'(aluControlE), 32'd1);
    chk("one_validE", 32'(validE), 32'd1);
    chk("one_vsE", 32'(isVectorScalarOperationE), 32'd1);
    chk("one_destE", 32'(destRegE), 32'd5);
    chk("one_validM_early", 32'(validM), 32'd0);
    tick();
    chk("one_validM", 32'(validM), 32'd1);
    chk("one_outFlagM", 32'(outFlagM), 32'd1);
    chk("one_validE_after", 32'(validE), 32'd0);
    tick();
    chk("one_weScalarW", 32'(writeEnableScalarW), 32'd1);
    chk("one_destW", 32'(destRegW), 32'd5);
    chk("one_rsW", 32'(resultSelectorW), 32'd1);
    tick();
    chk("one_weScalarW_gone", 32'(writeEnableScalarW), 32'd0);
    chk("one_validW_gone", 32'(validW), 32'd0);

    // Store held in M by a 2-cycle stall
    setD(1'b1, 3'b000, 3'b000, 2'b10, 3'b000, 4'd3);
    tick();
    clrD();
    tick();
    chk("st_wmM_0", 32'(writeToMemoryEnableM), 32'd1);
    stallAll = 1'b1;
    tick();
    chk("st_wmM_1", 32'(writeToMemoryEnableM), 32'd1);
    tick();
    chk("st_wmM_2", 32'(writeToMemoryEnableM), 32'd1);
    chk("st_validW_stalled", 32'(validW), 32'd0);
    stallAll = 1'b0;
    tick();
    chk("st_wmM_done", 32'(writeToMemoryEnableM), 32'd0);
    chk("st_validW", 32'(validW), 32'd1);
    chk("st_destW", 32'(destRegW), 32'd3);
    tick();

    // Four back-to-back instructions with one bubble; decode re-presents I3
    setD(1'b1, 3'b000, 3'b010, 2'b00, 3'b010, 4'd1);
    tick();
    chk("bs_destE_1", 32'(destRegE), 32'd1);
    setD(1'b1, 3'b000, 3'b010, 2'b00, 3'b010, 4'd2);
    tick();
    chk("bs_destE_2", 32'(destRegE), 32'd2);
    setD(1'b1, 3'b000, 3'b010, 2'b00, 3'b010, 4'd3);
    bubbleE = 1'b1;
    tick();
    bubbleE = 1'b0;
    chk("bs_nopE", 32'(validE), 32'd0);
    chk("bs_nopAluE", 32'(aluControlE), 32'd0);
    chk("bs_destW_1", 32'(destRegW), 32'd1);
    chk("bs_weW_1", 32'(writeEnableScalarW), 32'd1);
    tick();
    chk("bs_destE_3", 32'(destRegE), 32'd3);
    chk("bs_validM_nop", 32'(validM), 32'd0);
    chk("bs_destW_2", 32'(destRegW), 32'd2);
    setD(1'b1, 3'b000, 3'b010, 2'b00, 3'b010, 4'd4);
    tick();
    clrD();
    chk("bs_destE_4", 32'(destRegE), 32'd4);
    chk("bs_validW_nop", 32'(validW), 32'd0);
    chk("bs_weW_nop", 32'(writeEnableScalarW), 32'd0);
    tick();
    chk("bs_destW_3", 32'(destRegW), 32'd3);
    tick();
    chk("bs_destW_4", 32'(destRegW), 32'd4);
    tick();
    chk("bs_drained", 32'(validW), 32'd0);

    // stallAll and bubbleE on the same edge: nothing moves
    setD(1'b1, 3'b101, 3'b101, 2'b00, 3'b000, 4'd7);
    tick();
    setD(1'b1, 3'b000, 3'b011, 2'b00, 3'b000, 4'd9);
    stallAll = 1'b1;
    bubbleE  = 1'b1;
    tick();
    stallAll = 1'b0;
    bubbleE  = 1'b0;
    clrD();
    chk("sb_validE", 32'(validE), 32'd1);
    chk("sb_destE", 32'(destRegE), 32'd7);
    chk("sb_aluE", 32'(aluControlE), 32'd5);
    chk("sb_scalarE", 32'(isScalarInstructionE), 32'd1);
    chk("sb_immE", 32'(useInmediateE), 32'd1);
    chk("sb_validM", 32'(validM), 32'd0);
`ifdef CTRL_PIPE_PERF_EN
    chk("sb_bubbles", bubbleCount, 32'd1);
`endif
    tick();
    chk("sb_destM", 32'(destRegM), 32'd7);
    tick();
    tick();
    tick();

    // Non-valid decode with a vector write enable never writes
    setD(1'b0, 3'b000, 3'b111, 2'b00, 3'b001, 4'd6);
    tick();
    clrD();
    chk("nv_validE", 32'(validE), 32'd0);
    chk("nv_aluE", 32'(aluControlE), 32'd0);
    chk("nv_destE", 32'(destRegE), 32'd0);
    chk("nv_weVecW_1", 32'(writeEnableVectorW), 32'd0);
    tick();
    chk("nv_weVecW_2", 32'(writeEnableVectorW), 32'd0);
    tick();
    chk("nv_weVecW_3", 32'(writeEnableVectorW), 32'd0);

    // Reset with three instructions in flight
    setD(1'b1, 3'b111, 3'b011, 2'b11, 3'b111, 4'd10);
    tick();
    setD(1'b1, 3'b111, 3'b011, 2'b11, 3'b111, 4'd11);
    tick();
    setD(1'b1, 3'b111, 3'b011, 2'b11, 3'b111, 4'd12);
    tick();
    chk("mr_inflight", 32'({validE, validM, validW}), 32'b111);
    setD(1'b1, 3'b111, 3'b011, 2'b11, 3'b111, 4'd13);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clrD();
    chk("mr_valids", 32'({validE, validM, validW}), 32'd0);
    chk("mr_eCtrl", 32'({isScalarInstructionE, isVectorScalarOperationE, useInmediateE, aluControlE}), 32'd0);
    chk("mr_mCtrl", 32'({writeToMemoryEnableM, outFlagM}), 32'd0);
    chk("mr_wCtrl", 32'({resultSelectorW, writeEnableScalarW, writeEnableVectorW}), 32'd0);
    chk("mr_dests", 32'({destRegE, destRegM, destRegW}), 32'd0);
`ifdef CTRL_PIPE_PERF_EN
    chk("mr_retired", retiredCount, 32'd0);
    chk("mr_bubbles", bubbleCount, 32'd0);
`endif

    // Ten retirements: 10 issue edges plus 3 drain edges
    for (int i = 0; i < 10; i++) begin
      setD(1'b1, 3'b000, 3'b000, 2'b00, 3'b010, RW'(i + 1));
      tick();
    end
    clrD();
    chk("rt_destW_8", 32'(destRegW), 32'd8);
    tick();
    tick();
    tick();
    chk("rt_validW_empty", 32'(validW), 32'd0);
`ifdef CTRL_PIPE_PERF_EN
    chk("rt_retired", retiredCount, 32'd10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
